// File: rtl/tc_mem_pkg.sv
// Shared types for the two-requester memory arbiter.
// State encoding and address width used by every file.
package tc_mem_pkg;

    localparam int ADDR_WIDTH = 16;

    typedef enum logic [1:0] {
        CLEAR   = 2'd0,
        IDLE    = 2'd1,
        ISSUE   = 2'd2,
        CAPTURE = 2'd3
    } state_e;

endpackage

// File: rtl/tc_rr_arb2.sv
// Two-way round-robin grant, purely combinational.
// The requester that did not win last time wins a tie.
module tc_rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant,
    output logic [1:0] grant_oh
);

    // Pick a winner among the valid requesters.
    always_comb begin
        grant_oh = 2'b00;
        case (valid)
            2'b01:   grant_oh = 2'b01;
            2'b10:   grant_oh = 2'b10;
            2'b11:   grant_oh = last_grant ? 2'b01 : 2'b10;
            default: grant_oh = 2'b00;
        endcase
        grant = grant_oh[1];
    end

endmodule

// File: rtl/tc_mem_arbiter.sv
// Round-robin controller sharing one single-port memory
// between two requesters, with optional post-reset zero-fill.
module tc_mem_arbiter
    import tc_mem_pkg::*;
#(
    parameter int BIT_WIDTH      = 16,
    parameter int MEM_WORDS      = 256,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  r0_valid,
    input  logic                  r0_write,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [BIT_WIDTH-1:0]  r0_wdata,
    output logic                  r0_ready,
    output logic                  r0_rsp_valid,
    output logic [BIT_WIDTH-1:0]  r0_rdata,
    input  logic                  r1_valid,
    input  logic                  r1_write,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [BIT_WIDTH-1:0]  r1_wdata,
    output logic                  r1_ready,
    output logic                  r1_rsp_valid,
    output logic [BIT_WIDTH-1:0]  r1_rdata,
    output logic                  mem_rst,
    output logic                  mem_load,
    output logic                  mem_save,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [BIT_WIDTH-1:0]  mem_in,
    input  logic [BIT_WIDTH-1:0]  mem_out,
    output logic                  busy
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
        ADDR_WIDTH'(MEM_WORDS - 1);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
    logic                    last_grant_q, last_grant_d;
    logic                    cmd_id_q, cmd_id_d;
    logic                    cmd_write_q, cmd_write_d;
    logic                    mem_load_q, mem_load_d;
    logic                    mem_save_q, mem_save_d;
    logic [ADDR_WIDTH-1:0]   mem_address_q, mem_address_d;
    logic [BIT_WIDTH-1:0]    mem_in_q, mem_in_d;
    logic [1:0]              rsp_q, rsp_d;
    logic [1:0][BIT_WIDTH-1:0] rdata_q, rdata_d;

    logic                    grant;
    logic [1:0]              grant_oh;
    logic                    idle;
    logic                    sel_write;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [BIT_WIDTH-1:0]    sel_wdata;

    tc_rr_arb2 u_arb (
        .valid      ({r1_valid, r0_valid}),
        .last_grant (last_grant_q),
        .grant      (grant),
        .grant_oh   (grant_oh)
    );

    assign idle      = (state_q == IDLE);
    assign r0_ready  = idle & grant_oh[0];
    assign r1_ready  = idle & grant_oh[1];
    assign sel_write = grant ? r1_write : r0_write;
    assign sel_addr  = grant ? r1_addr  : r0_addr;
    assign sel_wdata = grant ? r1_wdata : r0_wdata;

    // Next-state, memory command and response generation.
    always_comb begin
        state_d       = state_q;
        clr_cnt_d     = clr_cnt_q;
        last_grant_d  = last_grant_q;
        cmd_id_d      = cmd_id_q;
        cmd_write_d   = cmd_write_q;
        mem_load_d    = 1'b0;
        mem_save_d    = 1'b0;
        mem_address_d = mem_address_q;
        mem_in_d      = mem_in_q;
        rsp_d         = 2'b00;
        rdata_d       = rdata_q;
        unique case (state_q)
            CLEAR: begin
                mem_save_d    = 1'b1;
                mem_address_d = clr_cnt_q;
                mem_in_d      = '0;
                clr_cnt_d     = clr_cnt_q + ADDR_WIDTH'(1);
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (|grant_oh) begin
                    last_grant_d  = grant;
                    cmd_id_d      = grant;
                    cmd_write_d   = sel_write;
                    mem_address_d = sel_addr;
                    mem_in_d      = sel_wdata;
                    mem_save_d    = sel_write;
                    mem_load_d    = ~sel_write;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_write_q) begin
                    rsp_d[cmd_id_q] = 1'b1;
                    state_d         = IDLE;
                end else begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                rdata_d[cmd_id_q] = mem_out;
                rsp_d[cmd_id_q]   = 1'b1;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset drops any command.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            clr_cnt_q     <= '0;
            last_grant_q  <= 1'b1;
            cmd_id_q      <= 1'b0;
            cmd_write_q   <= 1'b0;
            mem_load_q    <= 1'b0;
            mem_save_q    <= 1'b0;
            mem_address_q <= '0;
            mem_in_q      <= '0;
            rsp_q         <= 2'b00;
            rdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            clr_cnt_q     <= clr_cnt_d;
            last_grant_q  <= last_grant_d;
            cmd_id_q      <= cmd_id_d;
            cmd_write_q   <= cmd_write_d;
            mem_load_q    <= mem_load_d;
            mem_save_q    <= mem_save_d;
            mem_address_q <= mem_address_d;
            mem_in_q      <= mem_in_d;
            rsp_q         <= rsp_d;
            rdata_q       <= rdata_d;
        end
    end

    assign mem_rst      = 1'b0;
    assign mem_load     = mem_load_q;
    assign mem_save     = mem_save_q;
    assign mem_address  = mem_address_q;
    assign mem_in       = mem_in_q;
    assign r0_rsp_valid = rsp_q[0];
    assign r1_rsp_valid = rsp_q[1];
    assign r0_rdata     = rdata_q[0];
    assign r1_rdata     = rdata_q[1];
    assign busy         = ~idle;

endmodule
